ddr_mem_responder: RTL and testbench
====================================

Name: ddr_mem_responder

Overview:
- Synthesizable, BRAM-backed responder for the UberDDR3 request interface (memrequest_* signals); it is the target end of the interface that the traffic generator drives.
- Stands in for the DDR3 controller in simulation and board bring-up.
- Accepts read and write commands and completes them strictly in order after a fixed latency.
- Models controller backpressure: init time, periodic refresh, and an outstanding-command limit.

Parameters:
ADDR_WIDTH, 24, request address width
DATA_WIDTH, 128, data word width
DEPTH, 4096, stored words; must be a power of two; address aliases on its low log2(DEPTH) bits
LATENCY, 8, cycles from accept to completion (>=2)
MAX_OUTSTANDING, 6, accepted-but-not-completed limit (1..LATENCY)
INIT_CYCLES, 32, busy cycles after reset
REFRESH_PERIOD, 512, READY cycles between refreshes
REFRESH_CYCLES, 16, refresh duration

Ports:
clk  in  1  clock
rst  in  1  reset
memrequest_addr  in  ADDR_WIDTH  command address
memrequest_en  in  1  command request
memrequest_write_enable  in  1  1=write, 0=read
memrequest_write_data  in  DATA_WIDTH  write data
memrequest_resp_data  out  DATA_WIDTH  read data, valid with complete
memrequest_complete  out  1  one-cycle completion pulse per accepted command
memrequest_busy  out  1  commands not accepted this cycle
outstanding  out  log2(MAX_OUTSTANDING)+1  commands in flight
refresh_active  out  1  high in REFRESH state

Behaviour:
- Reset rst is synchronous and active-high; the clock is clk.
- Reset values: busy=1, complete=0, resp_data=0, outstanding=0, refresh_active=0, state=INIT. The pipeline is cleared. Memory contents are NOT reset.
- Busy derivation: busy is a function of registers only, with no combinational path from memrequest_en.
  - busy = (state!=READY) || (outstanding >= MAX_OUTSTANDING).
- Accept: accept = memrequest_en && !busy. While busy, en is ignored; no command is stored or queued.
- Accept behaviour, both kinds take effect in the accept cycle:
  - Write: mem[addr mod DEPTH] <= write_data.
  - Read: captures mem[addr mod DEPTH] into the pipeline. A read accepted the cycle after a write to the same address returns the new data.
- Pipeline: LATENCY-stage shift register carrying {valid, we, data}.
  - complete = valid at the final stage, i.e. exactly LATENCY cycles after the accept edge.
  - Completion is in order and happens for writes too.
  - resp_data = captured data for reads, 0 for writes, 0 when complete=0.
- Outstanding counter: +1 on accept, -1 on complete, unchanged when both occur in the same cycle. It never exceeds MAX_OUTSTANDING and never underflows.
- State machine:
  - INIT: count INIT_CYCLES, then go to READY.
  - READY: refresh counter increments each cycle. At REFRESH_PERIOD-1, go to REFRESH and clear the counter.
  - REFRESH: busy=1 and refresh_active=1 for REFRESH_CYCLES cycles, then return to READY.
- In-flight commands during REFRESH keep advancing and completing; refresh only blocks new accepts.
- An accept and a transition into REFRESH in the same cycle are legal: the accept happens because busy is from the prior state.
- Reset mid-operation: in-flight commands are dropped with no complete pulses; outstanding returns to 0 and INIT restarts.
- Address wrap: addresses >= DEPTH alias, e.g. 4096 maps to word 0 when DEPTH=4096. Upper address bits are ignored silently.

Test Plan:
1. Reset/init: deassert rst, hold en=1. busy=1 for exactly 32 cycles, then 0; the first accept occurs on cycle 32; no complete before cycle 40.
2. Write/read latency: write addr 5 data 0xA5..A5, then read addr 5 the next cycle. Complete pulses at +8 (resp_data=0) and +9 (resp_data=0xA5..A5).
3. Outstanding limit: en=1 with continuous reads. After 6 accepts busy goes 1. Thereafter one accept per complete; outstanding stays at or below 6; no lost or duplicate completes (compare against a scoreboard).
4. Refresh: run 600 cycles of alternating read/write traffic driven the way the traffic generator drives it. busy=1 and refresh_active=1 for 16 cycles every 512 READY cycles. Completions continue during refresh; data matches the scoreboard.
5. Aliasing: write addr 4096 data 0x1, then read addr 0 -> resp_data=0x1.
6. Reset mid-flight: accept 4 reads, assert rst for 1 cycle. Zero complete pulses afterwards, outstanding=0, busy high for 32 cycles. Previously written memory data reads back unchanged.

Source files
------------

// File: rtl/ddr_mem_responder_if.sv
// Request/response bundle of the UberDDR3 memrequest_* interface.
// The traffic generator drives it through the master modport; the
// responder terminates it through the slave modport.
interface ddr_mem_responder_if #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 128
);
  logic [ADDR_WIDTH-1:0] memrequest_addr;
  logic                  memrequest_en;
  logic                  memrequest_write_enable;
  logic [DATA_WIDTH-1:0] memrequest_write_data;
  logic [DATA_WIDTH-1:0] memrequest_resp_data;
  logic                  memrequest_complete;
  logic                  memrequest_busy;

  modport master (
    output memrequest_addr,
    output memrequest_en,
    output memrequest_write_enable,
    output memrequest_write_data,
    input  memrequest_resp_data,
    input  memrequest_complete,
    input  memrequest_busy
  );

  modport slave (
    input  memrequest_addr,
    input  memrequest_en,
    input  memrequest_write_enable,
    input  memrequest_write_data,
    output memrequest_resp_data,
    output memrequest_complete,
    output memrequest_busy
  );
endinterface

// File: rtl/ddr_mem_responder.sv
// BRAM-backed stand-in for the DDR3 controller. Commands are accepted when
// not busy, take effect on the memory in the accept cycle, and complete in
// order a fixed number of cycles later. Busy models controller init time,
// periodic refresh and a cap on commands in flight.
module ddr_mem_responder #(
  parameter int ADDR_WIDTH      = 24,
  parameter int DATA_WIDTH      = 128,
  parameter int DEPTH           = 4096,
  parameter int LATENCY         = 8,
  parameter int MAX_OUTSTANDING = 6,
  parameter int INIT_CYCLES     = 32,
  parameter int REFRESH_PERIOD  = 512,
  parameter int REFRESH_CYCLES  = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  ddr_mem_responder_if.slave                 req,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               refresh_active
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int OUT_W   = $clog2(MAX_OUTSTANDING) + 1;
  localparam int TMR_MAX = (INIT_CYCLES > REFRESH_PERIOD)
                           ? ((INIT_CYCLES > REFRESH_CYCLES) ? INIT_CYCLES : REFRESH_CYCLES)
                           : ((REFRESH_PERIOD > REFRESH_CYCLES) ? REFRESH_PERIOD : REFRESH_CYCLES);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_READY,
    ST_REFRESH
  } state_t;

  state_t                state;
  logic [TMR_W-1:0]      timer;
  logic [DATA_WIDTH-1:0] storage [DEPTH];
  logic [LATENCY-1:0]    pipe_valid;
  logic [DATA_WIDTH-1:0] pipe_data [LATENCY];
  logic [IDX_W-1:0]      idx;
  logic                  busy;
  logic                  accept;
  logic                  complete;
  logic                  addr_hi_unused;

  // Only the low address bits select a word; the rest alias silently.
  assign idx            = req.memrequest_addr[IDX_W-1:0];
  assign addr_hi_unused = ^req.memrequest_addr;

  // Busy comes only from registers so the requester sees no loop through en.
  assign busy     = (state != ST_READY) || (outstanding >= OUT_W'(MAX_OUTSTANDING));
  assign accept   = req.memrequest_en && !busy;
  assign complete = pipe_valid[LATENCY-1];

  assign req.memrequest_busy      = busy;
  assign req.memrequest_complete  = complete;
  assign req.memrequest_resp_data = pipe_data[LATENCY-1];
  assign refresh_active           = (state == ST_REFRESH);

  // Controller phase: init wait, then READY with refresh windows cut in periodically.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      timer <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (timer == TMR_W'(INIT_CYCLES - 1)) begin
            state <= ST_READY;
            timer <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_READY: begin
          if (timer == TMR_W'(REFRESH_PERIOD - 1)) begin
            state <= ST_REFRESH;
            timer <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_REFRESH: begin
          if (timer == TMR_W'(REFRESH_CYCLES - 1)) begin
            state <= ST_READY;
            timer <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: begin
          state <= ST_INIT;
          timer <= '0;
        end
      endcase
    end
  end

  // Write port of the storage array; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (!rst && accept && req.memrequest_write_enable) begin
      storage[idx] <= req.memrequest_write_data;
    end
  end

  // Completion pipeline: read data is captured at accept, writes carry zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_valid   <= {pipe_valid[LATENCY-2:0], accept};
      pipe_data[0] <= (accept && !req.memrequest_write_enable) ? storage[idx] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  // Commands in flight: accept adds one, completion removes one.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else if (accept && !complete) begin
      outstanding <= outstanding + OUT_W'(1);
    end else if (!accept && complete) begin
      outstanding <= outstanding - OUT_W'(1);
    end
  end

endmodule

// File: tb/tb_ddr_mem_responder.sv
// Self-checking bench for ddr_mem_responder. A reference memory and an
// analytic timing model predict busy/refresh per cycle; every accepted
// command pushes its expected completion onto a scoreboard queue that is
// popped when the completion is due.
module tb_ddr_mem_responder;

  localparam int ADDR_WIDTH      = 24;
  localparam int DATA_WIDTH      = 128;
  localparam int DEPTH           = 4096;
  localparam int LATENCY         = 8;
  localparam int MAX_OUTSTANDING = 6;
  localparam int INIT_CYCLES     = 32;
  localparam int REFRESH_PERIOD  = 512;
  localparam int REFRESH_CYCLES  = 16;

  typedef struct {
    int                    due;
    logic [DATA_WIDTH-1:0] data;
  } sb_entry_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] outstanding;
  logic       refresh_active;

  sb_entry_t             sb [$];
  logic [DATA_WIDTH-1:0] ref_mem [int];
  int checks;
  int failures;
  int cyc;
  bit last_accept;
  int first_accept_cyc;
  int first_complete_cyc;
  int max_outstanding;
  int refresh_seen;

  ddr_mem_responder_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

  ddr_mem_responder #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH),
    .LATENCY(LATENCY), .MAX_OUTSTANDING(MAX_OUTSTANDING), .INIT_CYCLES(INIT_CYCLES),
    .REFRESH_PERIOD(REFRESH_PERIOD), .REFRESH_CYCLES(REFRESH_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(bus.slave),
    .outstanding(outstanding),
    .refresh_active(refresh_active)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [DATA_WIDTH-1:0] actual,
                             input logic [DATA_WIDTH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", tag, actual, expected, cyc);
    end
  endtask

  // READY phases last REFRESH_PERIOD cycles, each followed by a refresh window.
  function automatic bit model_ready(input int t);
    int u;
    if (t < INIT_CYCLES) return 1'b0;
    u = (t - INIT_CYCLES) % (REFRESH_PERIOD + REFRESH_CYCLES);
    return u < REFRESH_PERIOD;
  endfunction

  function automatic bit model_refresh(input int t);
    return (t >= INIT_CYCLES) && !model_ready(t);
  endfunction

  // One clock: check outputs mid-cycle, model the accept, then advance.
  task automatic tick();
    bit        exp_busy;
    bit        exp_c;
    int        idx;
    sb_entry_t e;
    @(negedge clk);
    exp_busy = !model_ready(cyc) || (sb.size() >= MAX_OUTSTANDING);
    checkOutput("busy", bus.memrequest_busy, exp_busy);
    checkOutput("refresh_active", refresh_active, model_refresh(cyc));
    checkOutput("outstanding", outstanding, sb.size());
    if (int'(outstanding) > max_outstanding) max_outstanding = int'(outstanding);
    if (refresh_active) refresh_seen++;
    if (bus.memrequest_en && !bus.memrequest_busy && first_accept_cyc < 0) first_accept_cyc = cyc;
    if (bus.memrequest_complete && first_complete_cyc < 0) first_complete_cyc = cyc;
    exp_c = (sb.size() > 0) && (sb[0].due == cyc);
    checkOutput("complete", bus.memrequest_complete, exp_c);
    if (exp_c) begin
      e = sb.pop_front();
      checkOutput("resp_data", bus.memrequest_resp_data, e.data);
    end else begin
      checkOutput("resp_idle", bus.memrequest_resp_data, '0);
    end
    last_accept = bus.memrequest_en && !exp_busy;
    if (last_accept) begin
      idx   = int'(bus.memrequest_addr) % DEPTH;
      e.due = cyc + LATENCY;
      if (bus.memrequest_write_enable) begin
        ref_mem[idx] = bus.memrequest_write_data;
        e.data = '0;
      end else begin
        e.data = ref_mem.exists(idx) ? ref_mem[idx] : '0;
      end
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present one command and hold it until it is accepted, as the generator does.
  task automatic applyStimulus(input bit we, input int addr, input logic [DATA_WIDTH-1:0] data);
    int guard;
    bus.memrequest_en           = 1'b1;
    bus.memrequest_write_enable = we;
    bus.memrequest_addr         = ADDR_WIDTH'(addr);
    bus.memrequest_write_data   = data;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!last_accept && guard < 300);
    if (!last_accept) checkOutput("accept_timeout", 0, 1);
    bus.memrequest_en = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.memrequest_en = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain();
    int guard;
    bus.memrequest_en = 1'b0;
    guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      tick();
      guard++;
    end
    if (sb.size() > 0) checkOutput("drain_timeout", sb.size(), 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.memrequest_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    cyc = 0;
    first_accept_cyc   = -1;
    first_complete_cyc = -1;
    checkOutput("rst_busy", bus.memrequest_busy, 1);
    checkOutput("rst_complete", bus.memrequest_complete, 0);
    checkOutput("rst_resp_data", bus.memrequest_resp_data, '0);
    checkOutput("rst_outstanding", outstanding, 0);
    checkOutput("rst_refresh_active", refresh_active, 0);
  endtask

  // Bound the whole run so a stuck design still ends with a report.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios in sequence; the scoreboard checks every cycle.
  initial begin
    int start;
    int i;
    checks = 0;
    failures = 0;
    cyc = 0;
    rst = 1'b1;
    bus.memrequest_en           = 1'b0;
    bus.memrequest_write_enable = 1'b0;
    bus.memrequest_addr         = '0;
    bus.memrequest_write_data   = '0;
    do_reset(3);

    $display("[TB] init: command held from release of reset");
    applyStimulus(1'b1, 0, 128'h1111);
    drain();
    checkOutput("first_accept_cycle", first_accept_cyc, 32);
    checkOutput("first_complete_cycle", first_complete_cyc, 40);

    $display("[TB] write then read same address");
    applyStimulus(1'b1, 5, {16{8'hA5}});
    applyStimulus(1'b0, 5, '0);
    drain();
    for (int a = 0; a < 16; a++) begin
      if (a != 5) applyStimulus(1'b1, a, {$urandom, $urandom, $urandom, $urandom});
    end
    drain();

    $display("[TB] outstanding limit with continuous reads");
    max_outstanding = 0;
    for (int k = 0; k < 24; k++) applyStimulus(1'b0, k % 16, '0);
    drain();
    checkOutput("outstanding_peak", max_outstanding, MAX_OUTSTANDING);

    $display("[TB] alternating traffic across a refresh window");
    refresh_seen = 0;
    start = cyc;
    i = 0;
    while (cyc < start + 600) begin
      if (i % 2 == 0) applyStimulus(1'b1, (i / 2) % 16, {$urandom, $urandom, $urandom, $urandom});
      else applyStimulus(1'b0, ((i / 2) + 3) % 16, '0);
      i++;
    end
    drain();
    checkOutput("refresh_cycles", refresh_seen, REFRESH_CYCLES);

    $display("[TB] address aliasing");
    applyStimulus(1'b1, DEPTH, 128'h1);
    applyStimulus(1'b0, 0, '0);
    drain();

    $display("[TB] reset with reads in flight");
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, k, '0);
    do_reset(1);
    applyStimulus(1'b0, 5, '0);
    checkOutput("reaccept_cycle", first_accept_cyc, 32);
    applyStimulus(1'b0, 0, '0);
    applyStimulus(1'b0, 9, '0);
    drain();
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
